// File: rtl/shift_arb_pkg.sv
// Shared types and the round-robin pick function for the shift request arbiter.
package shift_arb_pkg;

  localparam int DATA_W  = 16;
  localparam int AMT_W   = 4;
  localparam int MAX_REQ = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // First valid index scanning upward from ptr, wrapping modulo nreq.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                    input logic [2:0] ptr,
                                    input int nreq);
    pick_t p;
    int    j;
    p = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      j = (int'(ptr) + k) % nreq;
      if (k < nreq && !p.found && valid[j[2:0]]) begin
        p.found = 1'b1;
        p.idx   = j[2:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/barrel_shift_16bit.sv
// Combinational 16-bit logical right barrel shifter, zero fill.
module barrel_shift_16bit (
  input  logic [15:0] in,
  input  logic [3:0]  ctrl,
  output logic [15:0] out
);

  logic [15:0] s1;
  logic [15:0] s2;
  logic [15:0] s4;

  assign s1  = ctrl[0] ? {1'b0, in[15:1]}  : in;
  assign s2  = ctrl[1] ? {2'b0, s1[15:2]}  : s1;
  assign s4  = ctrl[2] ? {4'b0, s2[15:4]}  : s2;
  assign out = ctrl[3] ? {8'b0, s4[15:8]}  : s4;

endmodule

// File: rtl/shift_req_arbiter.sv
// Round-robin sharing of one barrel shifter among NREQ requesters, with a
// one-deep registered response stage and a completed-response counter.
module shift_req_arbiter
  import shift_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*DATA_W-1:0] req_data,
  input  logic [NREQ*AMT_W-1:0]  req_amt,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_W-1:0]      rsp_data,
  output logic [IDW-1:0]         rsp_id,
  output logic [15:0]            done_cnt
);

  logic [IDW-1:0]    ptr;
  pick_t             pick;
  logic [IDW-1:0]    win;
  logic [IDW-1:0]    sel;
  logic              accept;
  logic              xfer;
  logic [DATA_W-1:0] shift_in;
  logic [AMT_W-1:0]  shift_amt;
  logic [DATA_W-1:0] shift_out;

  assign pick   = rr_pick(8'(req_valid), 3'(ptr), NREQ);
  assign win    = IDW'(pick.idx);
  assign accept = !rsp_valid || rsp_ready;
  assign xfer   = pick.found && accept && !rst;

  // With no winner the shifter just sees lane ptr; its output is ignored.
  assign sel       = pick.found ? win : ptr;
  assign shift_in  = req_data[sel*DATA_W +: DATA_W];
  assign shift_amt = req_amt[sel*AMT_W +: AMT_W];

  barrel_shift_16bit u_shift (
    .in   (shift_in),
    .ctrl (shift_amt),
    .out  (shift_out)
  );

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[win] = 1'b1;
  end

  // Response stage: load on grant, clear on drain, hold on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      ptr       <= '0;
      done_cnt  <= '0;
    end else begin
      if (rsp_valid && rsp_ready) done_cnt <= done_cnt + 16'd1;
      if (xfer) begin
        rsp_valid <= 1'b1;
        rsp_data  <= shift_out;
        rsp_id    <= win;
        ptr       <= IDW'((int'(win) + 1) % NREQ);
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule
